// File: rtl/parity_rx4.sv
// rtl/parity_rx4.sv - 4-bit parity-protected serial frame receiver with error LED and counter
module parity_rx4 #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       clr_err,
    output logic [3:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic       led
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic          rx_meta;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    shreg;
    logic          par_bit;

    logic bit_done;
    logic half_done;
    logic stop_edge;
    logic par_ok;
    logic frame_bad;
    logic par_bad;
    logic frame_good;
    logic err_event;

    // Both sync flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    assign bit_done   = (cnt == CNT_LAST);
    assign half_done  = (cnt == CNT_HALF);
    assign stop_edge  = (state == S_STOP) && bit_done;
    assign par_ok     = ((^shreg) ^ par_bit) == PARITY_ODD;
    assign frame_bad  = stop_edge && !rx_s;
    assign par_bad    = stop_edge && rx_s && !par_ok;
    assign frame_good = stop_edge && rx_s && par_ok;
    assign err_event  = frame_bad || par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= 2'd0;
            shreg   <= 4'd0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    // Mid-start check: a line already back high was only a glitch.
                    if (half_done) begin
                        cnt   <= '0;
                        idx   <= 2'd0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        idx        <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state <= S_PARITY;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
                    if (bit_done) begin
                        cnt   <= '0;
                        state <= rx_s ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= 4'd0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= frame_good;
            parity_err <= par_bad;
            frame_err  <= frame_bad;
            if (frame_good) begin
                rx_data <= shreg;
            end
        end
    end

    // A new error outranks a simultaneous clear so no error event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led     <= 1'b0;
            err_cnt <= 8'd0;
        end else if (err_event) begin
            led <= 1'b1;
            if (clr_err) begin
                err_cnt <= 8'd1;
            end else if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end else if (clr_err) begin
            led     <= 1'b0;
            err_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_parity_rx4.sv
// tb/tb_parity_rx4.sv - scoreboard bench for parity_rx4: frame tables, random frames, corner sequences
module tb_parity_rx4;

    localparam int CPB    = 8;
    localparam int K_GOOD = 4;
    localparam int K_PE   = 2;
    localparam int K_FE   = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       rxd_o;
    logic       clr_err;
    logic [3:0] rx_data, rx_data_o;
    logic       rx_valid, rx_valid_o;
    logic       parity_err, parity_err_o;
    logic       frame_err, frame_err_o;
    logic [7:0] err_cnt, err_cnt_o;
    logic       led, led_o;

    parity_rx4 #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .clr_err(clr_err),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .err_cnt(err_cnt), .led(led)
    );

    parity_rx4 #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_o), .clr_err(clr_err),
        .rx_data(rx_data_o), .rx_valid(rx_valid_o), .parity_err(parity_err_o),
        .frame_err(frame_err_o), .err_cnt(err_cnt_o), .led(led_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] d;
    } exp_t;

    typedef struct {
        logic [3:0] d;
        bit         p;
        bit         stop;
        int         kind;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       tbl[10];
    int         cyc = 0;
    logic       clr_q = 1'b0;
    int         nvec = 0;
    int         nerr = 0;
    logic [3:0] exp_data = 4'd0;
    int         exp_cnt = 0;
    bit         exp_led = 1'b0;
    int         odd_valid_n = 0;
    int         odd_perr_n = 0;
    logic [3:0] odd_last = 4'd0;

    task automatic chk(input string name, input int act, input int expv);
        nvec++;
        if (act != expv) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        clr_q <= clr_err;
    end

    // Reference: each pushed frame produces exactly one outcome 55 edges after its start is driven.
    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        int   exp_pulse;
        if (!rst_n) begin
            exp_q.delete();
            exp_data = 4'd0;
            exp_cnt  = 0;
            exp_led  = 1'b0;
        end else begin
            ev        = 1'b0;
            exp_pulse = 0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e         = exp_q.pop_front();
                ev        = 1'b1;
                exp_pulse = e.kind;
            end
            if (ev && e.kind == K_GOOD) exp_data = e.d;
            if (ev && e.kind != K_GOOD) begin
                exp_led = 1'b1;
                if (clr_q) exp_cnt = 1;
                else if (exp_cnt < 255) exp_cnt = exp_cnt + 1;
            end else if (clr_q) begin
                exp_led = 1'b0;
                exp_cnt = 0;
            end
            if (ev || {rx_valid, parity_err, frame_err} != 3'b000)
                chk("pulse", {rx_valid, parity_err, frame_err}, exp_pulse);
            chk("rx_data", rx_data, exp_data);
            chk("err_cnt", err_cnt, exp_cnt);
            chk("led", led, exp_led);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid_o) begin
                odd_valid_n++;
                odd_last = rx_data_o;
            end
            if (parity_err_o) odd_perr_n++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [3:0] d, input bit p, input bit stop,
                              input bit odd_line, input int kind, input bit push);
        logic [6:0] bits;
        bits = {stop, p, d, 1'b0};
        if (push) exp_q.push_back('{cyc + 55, kind, d});
        for (int i = 0; i < 7; i++) begin
            if (odd_line) rxd_o = bits[i];
            else rxd = bits[i];
            repeat (CPB) tick();
        end
        rxd_o = 1'b1;
    endtask

    function automatic int model_kind(input logic [3:0] d, input bit p, input bit stop);
        if (!stop) return K_FE;
        return ((d[0] + d[1] + d[2] + d[3] + p) % 2 == 0) ? K_GOOD : K_PE;
    endfunction

    initial begin
        int ov, op;
        rst_n   = 1'b0;
        rxd     = 1'b1;
        rxd_o   = 1'b1;
        clr_err = 1'b0;

        tbl[0] = '{4'hB, 1'b1, 1'b1, K_GOOD};
        tbl[1] = '{4'h6, 1'b1, 1'b1, K_PE};
        tbl[2] = '{4'h3, 1'b0, 1'b1, K_GOOD};
        tbl[3] = '{4'hA, 1'b0, 1'b1, K_GOOD};
        tbl[4] = '{4'h0, 1'b1, 1'b1, K_PE};
        tbl[5] = '{4'hF, 1'b0, 1'b1, K_GOOD};
        tbl[6] = '{4'h7, 1'b0, 1'b0, K_FE};
        tbl[7] = '{4'h1, 1'b1, 1'b1, K_GOOD};
        tbl[8] = '{4'hE, 1'b0, 1'b1, K_PE};
        tbl[9] = '{4'h5, 1'b0, 1'b1, K_GOOD};

        repeat (3) tick();
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_led", led, 0);
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].d, tbl[i].p, tbl[i].stop, 1'b0, tbl[i].kind, 1'b1);
            if (!tbl[i].stop) idle(4);
        end
        idle(4);

        // Break: framing error then line held low; only one error may result.
        send_frame(4'h7, 1'b0, 1'b0, 1'b0, K_FE, 1'b1);
        repeat (40) tick();
        idle(8);
        send_frame(4'h3, 1'b0, 1'b1, 1'b0, K_GOOD, 1'b1);
        idle(4);

        rxd = 1'b0;
        repeat (2) tick();
        idle(20);
        send_frame(4'hA, 1'b0, 1'b1, 1'b0, K_GOOD, 1'b1);
        idle(4);

        ov = odd_valid_n;
        op = odd_perr_n;
        send_frame(4'h6, 1'b1, 1'b1, 1'b1, K_GOOD, 1'b0);
        idle(4);
        chk("odd_valid_cnt", odd_valid_n - ov, 1);
        chk("odd_perr_cnt", odd_perr_n - op, 0);
        chk("odd_rx_data", odd_last, 4'h6);
        send_frame(4'h6, 1'b0, 1'b1, 1'b1, K_PE, 1'b0);
        idle(4);
        chk("odd_bad_valid_cnt", odd_valid_n - ov, 1);
        chk("odd_bad_perr_cnt", odd_perr_n - op, 1);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] d;
            bit p, s;
            d = 4'($urandom_range(0, 15));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, p, s, 1'b0, model_kind(d, p, s), 1'b1);
            if (!s) idle(4);
            else idle($urandom_range(0, 12));
        end
        idle(4);

        for (int i = 0; i < 300; i++)
            send_frame(4'h6, 1'b1, 1'b1, 1'b0, K_PE, 1'b1);
        idle(4);
        chk("sat_err_cnt", err_cnt, 255);
        chk("sat_led", led, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_led", led, 0);
        idle(2);

        fork
            send_frame(4'h6, 1'b1, 1'b1, 1'b0, K_PE, 1'b1);
            begin
                repeat (54) @(posedge clk);
                #1 clr_err = 1'b1;
                @(posedge clk);
                #1 clr_err = 1'b0;
            end
        join
        idle(2);
        chk("coinc_err_cnt", err_cnt, 1);
        chk("coinc_led", led, 1);

        rxd = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_rx_data", rx_data, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_led", led, 0);
        chk("arst_pulses", {rx_valid, parity_err, frame_err}, 0);
        rxd = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        idle(4);
        send_frame(4'h5, 1'b0, 1'b1, 1'b0, K_GOOD, 1'b1);
        idle(10);
        chk("post_rst_rx_data", rx_data, 4'h5);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/parity_rx4.md
# parity_rx4

Serial receiver that terminates the 4-bit parity-protected link: it deserializes frames of 1 start bit, 4 data bits, 1 parity bit and 1 stop bit from a single line. It checks the parity bit against the even/odd XOR of the nibble and reports good frames, parity errors and framing errors. It sits at the receive end of the safe-comm link, downstream of the transmitter's nibble-parity generator. It drives a sticky error LED and a saturating error counter for the board.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; even, ≥ 4; HALF = CLKS_PER_BIT/2
- PARITY_ODD, 0, 0 = even parity (XOR of d[3:0] and parity bit = 0); 1 = odd parity (XOR = 1)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- rxd  input  1  serial line, idle high, asynchronous to clk
- clr_err  input  1  synchronous clear of led and err_cnt
- rx_data  output  4  last good nibble
- rx_valid  output  1  one-cycle pulse per error-free frame
- parity_err  output  1  one-cycle pulse, parity mismatch
- frame_err  output  1  one-cycle pulse, stop bit sampled low
- err_cnt  output  8  saturating count of errored frames
- led  output  1  sticky error indicator

## Operation
- rxd passes through a 2-flop synchronizer (rx_s); both flops reset to 1.
- Bit order on the wire: start (0), d0, d1, d2, d3, parity, stop (1).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. The bit counter cnt is $clog2(CLKS_PER_BIT) bits wide; the bit index is 2 bits.
- IDLE: when rx_s = 0, go to START with cnt = 0.
- START: when cnt = HALF−1, check rx_s. If rx_s = 0, go to DATA with cnt = 0 and index = 0. If rx_s = 1, the start was a glitch: return to IDLE with no output and no error.
- DATA: when cnt = CLKS_PER_BIT−1, shift rx_s into bit[index] and reset cnt to 0. After index 3, go to PARITY.
- PARITY: when cnt = CLKS_PER_BIT−1, latch the parity bit and go to STOP.
- STOP: when cnt = CLKS_PER_BIT−1, sample the stop bit. Evaluate the frame on this edge:
  - stop = 0: assert frame_err and go to WAIT_IDLE. The parity result is discarded, so frame_err and parity_err are never both asserted.
  - stop = 1 and parity bad: assert parity_err and go to IDLE.
  - stop = 1 and parity good: load rx_data, assert rx_valid, go to IDLE.
- WAIT_IDLE: stay until rx_s = 1, then go to IDLE. This prevents a held-low line (break) from being read as new frames.
- rx_data changes only on good frames and holds its value otherwise.
- Error event = parity_err or frame_err. Each error event sets led and increments err_cnt, which saturates at 255.
- clr_err clears led and err_cnt to 0. If an error event occurs in the same cycle, the error wins: led = 1 and err_cnt = 1.
- Reset (asynchronous, any state): FSM goes to IDLE; cnt, index and shift register are cleared; any partial frame is abandoned without an error.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, err_cnt = 0, led = 0.
- E0 is the first rising edge that captures rxd = 0 in sync stage 1.
- Start is confirmed at edge E0 + 2 + HALF.
- Data bit k is sampled at E0 + 2 + HALF + (k+1)·CLKS_PER_BIT. Parity is sampled at +5·CLKS_PER_BIT, stop at +6·CLKS_PER_BIT.
- rx_valid, parity_err and frame_err are registered on the stop-sample edge. Each is high for exactly one cycle following edge E0 + 2 + HALF + 6·CLKS_PER_BIT (CLKS_PER_BIT = 8: the cycle after E54).
- led and err_cnt update on that same edge.
- Back-to-back frames: the FSM is back in IDLE at mid-stop-bit, so a start bit immediately following the stop bit is received with no lost frame.
- Minimum glitch rejected: any low pulse shorter than HALF−1 cycles at rx_s.

## Test plan
- CLKS_PER_BIT = 8, even parity. Send d = 4'hB, parity = 1, stop = 1 → rx_data = 4'hB, rx_valid single pulse in the cycle after E54; no errors; err_cnt = 0.
- Send d = 4'h6 with parity = 1 (wrong for even) → parity_err pulse; rx_data keeps its previous value; led = 1; err_cnt = 1. Repeat with PARITY_ODD = 1 → rx_valid with rx_data = 4'h6.
- Send a frame with stop = 0, then hold rxd low for 40 cycles, then release it high → exactly one frame_err and no further frames. Next valid frame 4'h3 → rx_valid.
- 2-cycle low glitch on idle rxd → no outputs change, FSM returns to IDLE. A following real frame 4'hA is received correctly.
- 300 consecutive parity-error frames → err_cnt = 255 (saturated). Then clr_err pulse → err_cnt = 0, led = 0. clr_err coincident with an error → err_cnt = 1, led = 1.
- Assert rst_n = 0 during the DATA state of a frame → all outputs 0 immediately, no error pulse. After release, frame 4'h5 → rx_valid with rx_data = 4'h5.
